// File: rtl/bmi_pkg.sv
// Shared constants and state encoding for the target-weight solver.
package bmi_pkg;

    localparam int W_DEF       = 8;
    localparam int DIVISOR_DEF = 100;
    localparam int LATENCY     = 5 * W_DEF + 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_H,
        MUL_B,
        DIV,
        FIN
    } state_t;

    function automatic int latency_cycles(input int w);
        return 5 * w + 1;
    endfunction

endpackage

// File: rtl/bmi_weight_solver_serial_divider.sv
// Serial restoring divider: 3W-bit dividend by W-bit divisor, one quotient bit per cycle, MSB first.
module serial_divider #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [3*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           running,
    output logic           done,
    output logic [3*W-1:0] quotient
);

    localparam int DW = $clog2(3 * W) + 1;
    localparam logic [DW-1:0] STEP_LAST = DW'(3 * W - 1);

    logic [W-1:0]   rem_reg, rem_next;
    logic [3*W-1:0] shift_reg, shift_next;
    logic [DW-1:0]  cnt_reg;
    logic           run_reg;

    logic [W-1:0]   src_rem;
    logic [3*W-1:0] src_shift;
    logic [W:0]     trial;
    logic           fits;

    // The start cycle performs the first step directly from the dividend input.
    always_comb begin
        src_rem    = start ? '0 : rem_reg;
        src_shift  = start ? dividend : shift_reg;
        trial      = {src_rem, src_shift[3*W-1]};
        fits       = (trial >= {1'b0, divisor});
        rem_next   = fits ? W'(trial[W-1:0] - divisor) : trial[W-1:0];
        shift_next = {src_shift[3*W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_reg   <= '0;
            shift_reg <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
        end else if (start) begin
            rem_reg   <= rem_next;
            shift_reg <= shift_next;
            cnt_reg   <= DW'(1);
            run_reg   <= 1'b1;
        end else if (run_reg) begin
            rem_reg   <= rem_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg + DW'(1);
            if (cnt_reg == STEP_LAST) begin
                run_reg <= 1'b0;
            end
        end
    end

    assign running  = run_reg;
    assign done     = run_reg && (cnt_reg == STEP_LAST);
    assign quotient = shift_reg;

endmodule

// File: rtl/bmi_weight_solver.sv
// Computes weight = bmi * height^2 / DIVISOR with serial multiplies and a serial divide.
// Define BMI_WEIGHT_ROUND_EN for round-half-up instead of truncation.
module bmi_weight_solver
    import bmi_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DIVISOR = DIVISOR_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] height,
    input  logic [W-1:0] bmi,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] weight,
    output logic         overflow
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(W - 1);
    localparam logic [W-1:0]   DIVISOR_W = W'(DIVISOR);
`ifdef BMI_WEIGHT_ROUND_EN
    localparam logic [3*W-1:0] ROUND_ADD = (3 * W)'(DIVISOR / 2);
`else
    localparam logic [3*W-1:0] ROUND_ADD = '0;
`endif

    state_t state_reg, state_next;

    logic [W-1:0]   h_reg, b_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2*W-1:0] h2_reg;
    logic [3*W-1:0] prod_reg;

    logic           accept, mul_last;
    logic           div_start, div_running, div_done;
    logic [3*W-1:0] quotient;
    logic [2*W-1:0] h_term;
    logic [3*W-1:0] b_term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        div_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = MUL_H;
                end
            end
            MUL_H:   if (mul_last) state_next = MUL_B;
            MUL_B:   if (mul_last) state_next = DIV;
            DIV: begin
                div_start = !div_running;
                if (div_done) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mul_last = (cnt_reg == CNT_LAST);
    assign h_term   = h_reg[cnt_reg] ? ({{W{1'b0}}, h_reg} << cnt_reg) : '0;
    assign b_term   = b_reg[cnt_reg] ? ({{W{1'b0}}, h2_reg} << cnt_reg) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_reg    <= '0;
            b_reg    <= '0;
            cnt_reg  <= '0;
            h2_reg   <= '0;
            prod_reg <= '0;
            weight   <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                h_reg    <= height;
                b_reg    <= bmi;
                cnt_reg  <= '0;
                h2_reg   <= '0;
                prod_reg <= '0;
            end
            case (state_reg)
                MUL_H: begin
                    h2_reg  <= h2_reg + h_term;
                    cnt_reg <= mul_last ? '0 : cnt_reg + CW'(1);
                end
                MUL_B: begin
                    // Rounding offset rides on the final partial product, so DIV starts on time.
                    prod_reg <= prod_reg + b_term + (mul_last ? ROUND_ADD : '0);
                    cnt_reg  <= mul_last ? '0 : cnt_reg + CW'(1);
                end
                FIN: begin
                    if (|quotient[3*W-1:W]) begin
                        weight   <= '1;
                        overflow <= 1'b1;
                    end else begin
                        weight   <= quotient[W-1:0];
                        overflow <= 1'b0;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

    serial_divider #(
        .W(W)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (prod_reg),
        .divisor  (DIVISOR_W),
        .running  (div_running),
        .done     (div_done),
        .quotient (quotient)
    );

endmodule

// File: tb/tb_bmi_weight_solver.sv
// Directed and random checks of bmi_weight_solver against an arithmetic reference model.
module tb_bmi_weight_solver;
    import bmi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] height, bmi;
    logic       busy, done, overflow;
    logic [7:0] weight;

    int n_checks = 0;
    int n_fail   = 0;

    bmi_weight_solver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .height   (height),
        .bmi      (bmi),
        .busy     (busy),
        .done     (done),
        .weight   (weight),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint observed, input longint expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic void model(input int h, input int b, output int w, output int ov);
        longint q;
        longint num;
        num = longint'(b) * h * h;
`ifdef BMI_WEIGHT_ROUND_EN
        num = num + DIVISOR_DEF / 2;
`endif
        q = num / DIVISOR_DEF;
        if (q > 255) begin
            w = 255; ov = 1;
        end else begin
            w = int'(q); ov = 0;
        end
    endfunction

    task automatic run_op(input int h, input int b, input string tag);
        int ew, eo, lat, busy_cnt;
        model(h, b, ew, eo);
        @(negedge clk);
        height = 8'(h); bmi = 8'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= LATENCY + 10 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
            else if (busy) busy_cnt++;
        end
        check({tag, " latency"}, lat, LATENCY);
        check({tag, " busy_cycles"}, busy_cnt, LATENCY);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " weight"}, weight, ew);
        check({tag, " overflow"}, overflow, eo);
        $display("op %s h=%0d b=%0d weight=%0d ovf=%0d lat=%0d", tag, h, b, weight, overflow, lat);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, done, 0);
    endtask

    initial begin
        int ew, eo, nd, de, last_e;
        int exp_w[$];
        int exp_o[$];
        int h, b;

        rst_n = 1'b0; start = 1'b0; height = '0; bmi = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset weight", weight, 0);
        check("reset overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(17, 22, "h17_b22");
        run_op(20, 63, "h20_b63");
        run_op(20, 64, "h20_b64");
        run_op(255, 255, "h255_b255");
        run_op(0, 200, "h0_b200");
        run_op(18, 25, "h18_b25");
        run_op(40, 0, "h40_b0");
        for (int i = 0; i < 8; i++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "random");
        end

        // Start pulse and operand changes while busy must be ignored.
        model(30, 25, ew, eo);
        @(negedge clk);
        height = 8'd30; bmi = 8'd25; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0; de = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (done) begin nd++; de = e; end
            if (e == 9) begin start = 1'b1; height = 8'd99; bmi = 8'd77; end
            if (e == 10) start = 1'b0;
            if (e == 11) begin height = 8'd5; bmi = 8'd6; end
        end
        check("ignore done_count", nd, 1);
        check("ignore done_edge", de, LATENCY);
        check("ignore weight", weight, ew);
        check("ignore overflow", overflow, eo);
        $display("op ignore h=30 b=25 weight=%0d dones=%0d", weight, nd);

        // Reset in the middle of an operation.
        @(negedge clk);
        height = 8'd40; bmi = 8'd30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset weight", weight, 0);
        check("midreset overflow", overflow, 0);
        rst_n = 1'b1;
        nd = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("midreset no_done", nd, 0);
        $display("op midreset dones_after=%0d", nd);
        run_op(17, 22, "after_reset");

        // Start held high: one accept per result, spaced 5W+2 apart.
        h = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
        model(h, b, ew, eo); exp_w.push_back(ew); exp_o.push_back(eo);
        @(negedge clk);
        height = 8'(h); bmi = 8'(b); start = 1'b1;
        @(posedge clk); #1;
        nd = 0; last_e = 0;
        for (int e = 1; e <= 3 * (LATENCY + 1) + 5; e++) begin
            @(posedge clk); #1;
            if (done) begin
                check("held done_edge", e, LATENCY + (LATENCY + 1) * nd);
                check("held weight", weight, exp_w[nd]);
                check("held overflow", overflow, exp_o[nd]);
                $display("op held idx=%0d edge=%0d weight=%0d ovf=%0d", nd, e, weight, overflow);
                nd++;
                last_e = e;
                if (nd < 3) begin
                    h = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
                    model(h, b, ew, eo); exp_w.push_back(ew); exp_o.push_back(eo);
                    height = 8'(h); bmi = 8'(b);
                end else begin
                    start = 1'b0;
                end
            end
        end
        check("held done_count", nd, 3);
        check("held last_edge", last_e, LATENCY + 2 * (LATENCY + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bmi_weight_solver.md
Name: bmi_weight_solver

Overview:
- Inverse of the BMI category computation: from a target BMI value and a height, computes the weight that yields that BMI.
- Formula: weight = bmi * height^2 / DIVISOR.
- Sequential, multi-cycle unit: a serial shift-add multiplier feeds a serial restoring divider, with a start/done handshake.
- Sits beside the BMI calculator so the front-end can display a "target weight" for a chosen category.

Parameters:
- W, 8, width of the height, bmi and weight operands; internal product width is 3*W.
- DIVISOR, 100, scaling constant. Must be nonzero and less than 2^W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; accepted only in IDLE.
- height  input  W  height operand, same units as the BMI calculator (decimetres).
- bmi  input  W  target BMI value.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when the result is valid.
- weight  output  W  result; held until the next accepted start.
- overflow  output  1  quotient exceeded 2^W-1 and weight is saturated; held with weight.

Behaviour:
- Reset (rst_n=0 at a rising edge) clears all outputs to 0 and sets state to IDLE. Reset wins over every other event, including mid-operation; a partial result is discarded and no done pulse occurs.
- IDLE: on start=1, latch height and bmi, clear the accumulator and counter, assert busy, go to MUL_H. While not in IDLE, start is ignored and the latched operands stay unaffected by input changes.
- MUL_H, W cycles: shift-add computes height*height into a 2W register, one multiplier bit per cycle.
- MUL_B, W cycles: shift-add computes h2*bmi into a 3W dividend register.
- DIV, 3W cycles: restoring division of the dividend by DIVISOR, one quotient bit per cycle, MSB first.
- FIN, 1 cycle:
  - If quotient > 2^W-1: weight = all ones, overflow = 1.
  - Otherwise: weight = quotient[W-1:0], overflow = 0.
  - Assert done=1, deassert busy, go to IDLE.
- Latency: the accept edge is edge 0; done is high during the cycle following edge 5W+1 (41 for W=8), and busy is high for 5W+1 cycles.
- start in the same cycle as done (FSM already in IDLE on the next edge) is accepted normally; back-to-back throughput is one result per 5W+2 cycles.
- height=0 or bmi=0: the full sequence still runs; result is weight=0, overflow=0, with the same latency (no early exit).
- Arithmetic: all unsigned. The maximum product (2^W-1)^3 fits 3W bits, so there is no intermediate overflow.
- Default result is truncation (floor).
- weight and overflow change only at FIN or reset.

Optional Feature:
- Macro: BMI_WEIGHT_ROUND_EN.
- When defined: DIVISOR/2 (50) is added to the dividend before DIV, giving round-half-up. The 3W-bit dividend has enough headroom for the addition; latency is unchanged, because the addition occurs on the MUL_B to DIV transition.
- When undefined: plain truncation.

Decomposition:
- Package bmi_pkg holds:
  - the state enum typedef (IDLE, MUL_H, MUL_B, DIV, FIN);
  - the default W and DIVISOR constants;
  - the latency constant 5W+1, which the bench also uses.
- One sub-module is natural: serial_divider (3W-bit dividend, W-bit divisor, start/done, 3W-cycle restoring divide). The multiplies stay in the top FSM.

Test Plan:
- height=17, bmi=22 -> product 6358; weight=63, overflow=0; done exactly 41 cycles after accept, busy high for 41 cycles. With BMI_WEIGHT_ROUND_EN: weight=64.
- height=20, bmi=63 -> weight=252, overflow=0. Then height=20, bmi=64 -> quotient 256, so weight=255, overflow=1. Also height=255, bmi=255 -> weight=255, overflow=1.
- height=0, bmi=200 -> weight=0, overflow=0, still 41-cycle latency. height=18, bmi=25 -> weight=81 exactly, identical with and without rounding.
- While busy: pulse start at cycle 10 and change height/bmi at cycle 12 -> ignored; the result matches the originally latched operands, with a single done pulse.
- Reset at cycle 20 of an operation -> on the next edge busy=0, done=0, weight=0, overflow=0. No done pulse for the aborted request; a fresh start afterwards completes correctly.
- start held high continuously -> a new operation is accepted on the edge after each done, with results spaced 42 cycles apart and no dropped or duplicated done pulses.
